hyperbus_ddr_out_bank: RTL
==========================

HYPERBUS_DDR_OUT_BANK -- requirements
Module: hyperbus_ddr_out_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of DDR output lanes (1..32).
REQ-002 SHALL have parameter DEPTH, default 2, beat FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter INIT, default '0, WIDTH-bit idle level driven while IDLE.
REQ-004 SHALL have port clk_i  input  1  sole clock; high phase shows d0, low phase shows d1.
REQ-005 SHALL have port rst_i  input  1  reset; one clock, reset synchronous and active-high.
REQ-006 SHALL have port flush_i  input  1  discard FIFO contents, return to IDLE.
REQ-007 SHALL have port valid_i  input  1  beat offered.
REQ-008 SHALL have port ready_o  output  1  beat accepted when valid_i&ready_o at posedge.
REQ-009 SHALL have port d0_i  input  WIDTH  rising-half data.
REQ-010 SHALL have port d1_i  input  WIDTH  falling-half data.
REQ-011 SHALL have port last_i  input  1  beat closes the burst.
REQ-012 SHALL have port q_o  output  WIDTH  DDR output.
REQ-013 SHALL have port busy_o  output  1  state != IDLE or FIFO non-empty.
REQ-014 SHALL have port underrun_o  output  1  one-cycle pulse on ACTIVE->STALL.

Function
REQ-015 SHALL store {d0,d1,last} beats in a DEPTH-entry FIFO; ready_o = !full, with no pass-through when full even if a pop occurs that cycle.
REQ-016 SHALL pop one beat per cycle whenever FIFO non-empty and flush_i=0, loading registers q0<=d0, q1<=d1.
REQ-017 SHALL drive q_o = q0 while clk_i high and q1 while clk_i low, per lane.
REQ-018 SHALL give latency: beat accepted at edge k appears on q_o in the cycle following edge k+1.
REQ-019 SHALL implement states IDLE, ACTIVE, STALL.
REQ-020 SHALL transition IDLE->ACTIVE on pop; ACTIVE->IDLE on pop of beat with last=1; ACTIVE->STALL when FIFO empty and last not yet popped; STALL->ACTIVE on pop.
REQ-021 SHALL load q0=q1=INIT on entering IDLE; SHALL hold last q0/q1 values in STALL.
REQ-022 SHALL assert underrun_o for exactly the cycle after the ACTIVE->STALL edge; no repeat while remaining in STALL.
REQ-023 SHALL on flush_i=1: empty FIFO, drop any simultaneous push (ready_o still reflects pre-flush full), state<=IDLE, q0=q1<=INIT at that edge.
REQ-024 SHALL handle FIFO pointer wrap-around with (log2(DEPTH)+1)-bit pointers; simultaneous push and pop keeps occupancy unchanged.
REQ-025 SHALL, when a popped beat has last=1 and the FIFO still holds beats, enter IDLE for exactly one cycle (INIT on q_o) before re-entering ACTIVE.

Reset
REQ-026 SHALL on rst_i=1 at posedge: state IDLE, FIFO empty, q0=q1=INIT, underrun_o=0, busy_o=0, ready_o=1 after reset.
REQ-027 SHALL treat reset mid-burst identically to REQ-026; partial bursts are discarded.

Configuration
REQ-028 SHALL, with HYPERBUS_DDR_OUT_OE_EN defined, provide output oe_o (1 bit), registered, 1 in ACTIVE/STALL, 0 in IDLE/reset, changing at the same edge as q0/q1.
REQ-029 SHALL, without HYPERBUS_DDR_OUT_OE_EN, omit oe_o entirely and leave all other behaviour unchanged.

Structure
REQ-030 SHALL place the state enum (IDLE, ACTIVE, STALL) and default WIDTH/DEPTH constants in package hyperbus_ddr_pkg.
REQ-031 SHALL instantiate pulp_clock_mux2 once per lane (clk0_i=q1, clk1_i=q0, clk_sel_i=clk_i); no other sub-module.

Verification
REQ-032 SHALL cover: WIDTH=8, push {d0=A5,d1=3C,last=1} after reset -> q_o A5/3C in one cycle, then INIT=00, busy_o returns 0.
REQ-033 SHALL cover: 3-beat burst with valid_i gap of 2 cycles after beat 1 -> underrun_o single pulse, q_o holds beat-1 values for 2 cycles, resumes.
REQ-034 SHALL cover: DEPTH=2, valid_i held high while downstream pops -> ready_o never 1 while full, 16 beats delivered in order, no loss across pointer wrap.
REQ-035 SHALL cover: flush_i asserted with 2 beats queued and valid_i=1 -> next cycle FIFO empty, q_o=INIT, pushed beat dropped.
REQ-036 SHALL cover: rst_i pulsed mid-burst with HYPERBUS_DDR_OUT_OE_EN defined -> oe_o=0, q_o=INIT, ready_o=1 the cycle after reset.
REQ-037 SHALL cover: back-to-back bursts (last=1 followed by queued beat) -> exactly one INIT cycle between bursts, oe_o low for that cycle.

Source files
------------

// File: rtl/hyperbus_ddr_pkg.sv
// Shared types and default sizing for the HyperBus DDR output bank.
// Holds the output-sequencer state encoding and the default lane count and FIFO depth.
package hyperbus_ddr_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_e;

endpackage

// File: rtl/pulp_clock_mux2.sv
// Per-lane 2:1 glitch-tolerant selector used to drive DDR halves from the clock phase.
// Zero latency; purely combinational, no backpressure.
// clk_o follows clk1_i while clk_sel_i is high, otherwise clk0_i.
module pulp_clock_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/hyperbus_ddr_out_bank.sv
// DDR output bank: queues {d0,d1,last} beats and plays them out as q0 (clk high) / q1 (clk low).
// Latency: beat accepted at edge k is shown in the cycle after edge k+1; oe_o under HYPERBUS_DDR_OUT_OE_EN.
// Backpressure: ready_o = !full; one INIT cycle is inserted after every beat carrying last.
module hyperbus_ddr_out_bank
    import hyperbus_ddr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             last_i,
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o,
    output logic             underrun_o
`ifdef HYPERBUS_DDR_OUT_OE_EN
    ,
    output logic             oe_o
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic             last;
    } beat_t;

    beat_t            mem_q [DEPTH];
    beat_t            mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] q0_q, q0_d;
    logic [WIDTH-1:0] q1_q, q1_d;
    logic             last_q, last_d;
    logic             underrun_q, underrun_d;

    logic  empty, full, push, pop;
    beat_t head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign ready_o = !full;
    assign push    = valid_i && !full && !flush_i;
    // Holding the pop while the shown beat closed a burst yields the single INIT gap cycle.
    assign pop     = !empty && !flush_i && !(state_q == ACTIVE && last_q);

    assign busy_o     = (state_q != IDLE) || !empty;
    assign underrun_o = underrun_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        state_d    = state_q;
        q0_d       = q0_q;
        q1_d       = q1_q;
        last_d     = last_q;
        underrun_d = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{d0: d0_i, d1: d1_i, last: last_i};
        end

        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            state_d  = IDLE;
            q0_d     = INIT;
            q1_d     = INIT;
            last_d   = 1'b0;
        end else if (pop) begin
            state_d = ACTIVE;
            q0_d    = head.d0;
            q1_d    = head.d1;
            last_d  = head.last;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (last_q) begin
                        state_d = IDLE;
                        q0_d    = INIT;
                        q1_d    = INIT;
                        last_d  = 1'b0;
                    end else begin
                        state_d    = STALL;
                        underrun_d = 1'b1;
                    end
                end
                IDLE: begin
                    q0_d = INIT;
                    q1_d = INIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            q0_q       <= INIT;
            q1_q       <= INIT;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef HYPERBUS_DDR_OUT_OE_EN
    logic oe_q, oe_d;

    assign oe_d = (state_d != IDLE);
    assign oe_o = oe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oe_q <= 1'b0;
        end else begin
            oe_q <= oe_d;
        end
    end
`endif

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
        pulp_clock_mux2 u_mux (
            .clk0_i   (q1_q[i]),
            .clk1_i   (q0_q[i]),
            .clk_sel_i(clk_i),
            .clk_o    (q_o[i])
        );
    end

endmodule
